// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control unit for the RV32 core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It uses ready handshakes to
// instruction and data memory and drives the datapath controls.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   opcode_in/funct3_in/funct7_in  instruction register fields
//   imem_ready, dmem_ready      memory handshakes (Mealy inputs)
//   imem_req, ir_write          fetch request / IR latch strobe
//   mem_read, mem_write         data memory requests
//   alu_src_mux (1b)            0 = register, 1 = immediate
//   alu_op (4b)                 AND 0000, OR 0001, ADD 0010, SUB 0110
//   reg_write, reg_src_mux (1b) writeback enable / source (0 = ALU, 1 = memory)
//   branch_ctrl, branch_inv     branch enable / branch on "not zero"
//   pc_advance                  PC update strobe, also the retire strobe
//   illegal_instr, bus_error    sticky traps, cleared only by rst
//   retire_count                retired instruction count, wraps
module multicycle_ctrl #(
    parameter bit          ENABLE_IMM_ALU = 1'b1,
    parameter bit          ENABLE_BNE     = 1'b1,
    parameter int unsigned MEM_TIMEOUT    = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode_in,
    input  logic [2:0]       funct3_in,
    input  logic [6:0]       funct7_in,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src_mux,
    output logic [3:0]       alu_op,
    output logic             reg_write,
    output logic             reg_src_mux,
    output logic             branch_ctrl,
    output logic             branch_inv,
    output logic             pc_advance,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic       ALU_SRC_REG = 1'b0;
    localparam logic       ALU_SRC_IMM = 1'b1;
    localparam logic [3:0] OP_AND      = 4'b0000;
    localparam logic [3:0] OP_OR       = 4'b0001;
    localparam logic [3:0] OP_ADD      = 4'b0010;
    localparam logic [3:0] OP_SUB      = 4'b0110;
    localparam logic       REG_SRC_ALU = 1'b0;
    localparam logic       REG_SRC_MEM = 1'b1;

    localparam int unsigned TmoW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;
    typedef enum logic [3:0] {
        ClsAdd, ClsSub, ClsAnd, ClsOr, ClsAddi, ClsAndi, ClsOri, ClsLd, ClsSd, ClsBeq, ClsBne
    } cls_e;

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d, dec_cls;
    logic              dec_ok;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              tmo_hit, waiting;
    logic              illegal_q, illegal_set;
    logic              bus_q, bus_set;
    logic [CNT_W-1:0]  retire_q;

    function automatic logic [3:0] op_of(cls_e c);
        case (c)
            ClsAdd, ClsAddi, ClsLd, ClsSd: op_of = OP_ADD;
            ClsSub, ClsBeq, ClsBne:        op_of = OP_SUB;
            ClsOr, ClsOri:                 op_of = OP_OR;
            default:                       op_of = OP_AND;
        endcase
    endfunction

    function automatic logic imm_of(cls_e c);
        imm_of = (c == ClsAddi) || (c == ClsAndi) || (c == ClsOri) || (c == ClsLd) ||
                 (c == ClsSd);
    endfunction

    // Instruction classification from the IR fields; only consumed in DECODE.
    always_comb begin
        dec_cls = ClsAdd;
        dec_ok  = 1'b0;
        case (opcode_in)
            7'b0110011: begin
                if (funct3_in == 3'b000 && funct7_in == 7'b0000000) begin
                    dec_cls = ClsAdd; dec_ok = 1'b1;
                end else if (funct3_in == 3'b000 && funct7_in == 7'b0100000) begin
                    dec_cls = ClsSub; dec_ok = 1'b1;
                end else if (funct3_in == 3'b111 && funct7_in == 7'b0000000) begin
                    dec_cls = ClsAnd; dec_ok = 1'b1;
                end else if (funct3_in == 3'b110 && funct7_in == 7'b0000000) begin
                    dec_cls = ClsOr; dec_ok = 1'b1;
                end
            end
            7'b0010011: begin
                if (ENABLE_IMM_ALU) begin
                    case (funct3_in)
                        3'b000:  begin dec_cls = ClsAddi; dec_ok = 1'b1; end
                        3'b111:  begin dec_cls = ClsAndi; dec_ok = 1'b1; end
                        3'b110:  begin dec_cls = ClsOri;  dec_ok = 1'b1; end
                        default: ;
                    endcase
                end
            end
            7'b0000011: begin dec_cls = ClsLd; dec_ok = 1'b1; end
            7'b0100011: begin dec_cls = ClsSd; dec_ok = 1'b1; end
            7'b1100011: begin
                if (funct3_in == 3'b000) begin
                    dec_cls = ClsBeq; dec_ok = 1'b1;
                end else if (funct3_in == 3'b001 && ENABLE_BNE) begin
                    dec_cls = ClsBne; dec_ok = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Counter is compared against the limit before the request is driven, so the request
    // drops in the very cycle the limit is reached.
    assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_q == TmoW'(MEM_TIMEOUT));
    assign waiting = ((state_q == StFetch) && !imem_ready) || ((state_q == StMem) && !dmem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            cls_q     <= ClsAdd;
            tmo_q     <= '0;
            illegal_q <= 1'b0;
            bus_q     <= 1'b0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            tmo_q     <= tmo_d;
            illegal_q <= illegal_q | illegal_set;
            bus_q     <= bus_q | bus_set;
            if (pc_advance) retire_q <= retire_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        illegal_set = 1'b0;
        bus_set     = 1'b0;
        case (state_q)
            StFetch: begin
                if (tmo_hit) begin
                    state_d = StTrap; bus_set = 1'b1;
                end else if (imem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_ok) begin
                    cls_d = dec_cls; state_d = StExec;
                end else begin
                    illegal_set = 1'b1; state_d = StTrap;
                end
            end
            StExec: begin
                if (cls_q == ClsBeq || cls_q == ClsBne)     state_d = StFetch;
                else if (cls_q == ClsLd || cls_q == ClsSd) state_d = StMem;
                else                                        state_d = StWb;
            end
            StMem: begin
                if (tmo_hit) begin
                    state_d = StTrap; bus_set = 1'b1;
                end else if (dmem_ready) begin
                    state_d = (cls_q == ClsLd) ? StWb : StFetch;
                end
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
        // Any state change restarts the wait counter.
        if (state_d != state_q)          tmo_d = '0;
        else if (waiting && !tmo_hit)    tmo_d = tmo_q + TmoW'(1);
        else                             tmo_d = tmo_q;
    end

    // Outputs are held at defaults during the reset cycle so in-flight requests drop.
    always_comb begin
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_src_mux = ALU_SRC_REG;
        alu_op      = OP_AND;
        reg_write   = 1'b0;
        reg_src_mux = REG_SRC_ALU;
        branch_ctrl = 1'b0;
        branch_inv  = 1'b0;
        pc_advance  = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    imem_req = !tmo_hit;
                    ir_write = imem_ready && !tmo_hit;
                end
                StExec: begin
                    alu_op      = op_of(cls_q);
                    alu_src_mux = imm_of(cls_q);
                    if (cls_q == ClsBeq || cls_q == ClsBne) begin
                        branch_ctrl = 1'b1;
                        branch_inv  = (cls_q == ClsBne);
                        pc_advance  = 1'b1;
                    end
                end
                StMem: begin
                    alu_src_mux = ALU_SRC_IMM;
                    alu_op      = OP_ADD;
                    if (!tmo_hit) begin
                        mem_read   = (cls_q == ClsLd);
                        mem_write  = (cls_q == ClsSd);
                        pc_advance = (cls_q == ClsSd) && dmem_ready;
                    end
                end
                StWb: begin
                    reg_write   = 1'b1;
                    pc_advance  = 1'b1;
                    alu_op      = op_of(cls_q);
                    alu_src_mux = imm_of(cls_q);
                    reg_src_mux = (cls_q == ClsLd) ? REG_SRC_MEM : REG_SRC_ALU;
                end
                default: ;
            endcase
        end
    end

    assign illegal_instr = illegal_q;
    assign bus_error     = bus_q;
    assign retire_count  = retire_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. Two instances share stimulus: dut_a (BNE on, 4-cycle
// timeout, 4-bit retire counter) and dut_b (BNE off, defaults otherwise).
module tb_multicycle_ctrl;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       reg_write;
        logic       reg_src;
        logic       branch_ctrl;
        logic       branch_inv;
        logic       pc_advance;
    } outs_t;

    typedef struct packed {
        logic  rst;
        logic  irdy;
        logic  drdy;
        logic  to;
        logic  ill;
        outs_t exp;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic [6:0] funct7 = 7'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;

    logic       a_imem_req, a_ir_write, a_mem_read, a_mem_write, a_alu_src, a_reg_write;
    logic       a_reg_src, a_branch_ctrl, a_branch_inv, a_pc_advance, a_illegal, a_bus;
    logic [3:0] a_alu_op;
    logic [3:0] a_retire;

    logic        b_imem_req, b_ir_write, b_mem_read, b_mem_write, b_alu_src, b_reg_write;
    logic        b_reg_src, b_branch_ctrl, b_branch_inv, b_pc_advance, b_illegal, b_bus;
    logic [3:0]  b_alu_op;
    logic [31:0] b_retire;

    outs_t a_outs;
    assign a_outs = {a_imem_req, a_ir_write, a_mem_read, a_mem_write, a_alu_src, a_alu_op,
                     a_reg_write, a_reg_src, a_branch_ctrl, a_branch_inv, a_pc_advance};

    multicycle_ctrl #(
        .ENABLE_IMM_ALU(1'b1), .ENABLE_BNE(1'b1), .MEM_TIMEOUT(4), .CNT_W(4)
    ) dut_a (
        .clk(clk), .rst(rst), .opcode_in(opcode), .funct3_in(funct3), .funct7_in(funct7),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(a_imem_req),
        .ir_write(a_ir_write), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .alu_src_mux(a_alu_src), .alu_op(a_alu_op), .reg_write(a_reg_write),
        .reg_src_mux(a_reg_src), .branch_ctrl(a_branch_ctrl), .branch_inv(a_branch_inv),
        .pc_advance(a_pc_advance), .illegal_instr(a_illegal), .bus_error(a_bus),
        .retire_count(a_retire)
    );

    multicycle_ctrl #(
        .ENABLE_IMM_ALU(1'b1), .ENABLE_BNE(1'b0), .MEM_TIMEOUT(16), .CNT_W(32)
    ) dut_b (
        .clk(clk), .rst(rst), .opcode_in(opcode), .funct3_in(funct3), .funct7_in(funct7),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(b_imem_req),
        .ir_write(b_ir_write), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .alu_src_mux(b_alu_src), .alu_op(b_alu_op), .reg_write(b_reg_write),
        .reg_src_mux(b_reg_src), .branch_ctrl(b_branch_ctrl), .branch_inv(b_branch_inv),
        .pc_advance(b_pc_advance), .illegal_instr(b_illegal), .bus_error(b_bus),
        .retire_count(b_retire)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    step_t      step_q[$];
    string      tag_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [3:0] exp_retire = 4'd0;
    logic       exp_ill = 1'b0;
    logic       exp_bus = 1'b0;
    logic       b_chk = 1'b0;
    int         b_hold = 0;

    function automatic outs_t o_fetch(input logic ir);
        outs_t o = '0;
        o.imem_req = 1'b1;
        o.ir_write = ir;
        return o;
    endfunction

    function automatic outs_t o_exec(input logic [3:0] op, input logic src, input logic br,
                                     input logic inv);
        outs_t o = '0;
        o.alu_op      = op;
        o.alu_src     = src;
        o.branch_ctrl = br;
        o.branch_inv  = inv;
        o.pc_advance  = br;
        return o;
    endfunction

    function automatic outs_t o_mem(input logic rd, input logic wr, input logic adv);
        outs_t o = '0;
        o.alu_src    = 1'b1;
        o.alu_op     = OP_ADD;
        o.mem_read   = rd;
        o.mem_write  = wr;
        o.pc_advance = adv;
        return o;
    endfunction

    function automatic outs_t o_wb(input logic [3:0] op, input logic src, input logic rs);
        outs_t o = '0;
        o.reg_write  = 1'b1;
        o.pc_advance = 1'b1;
        o.alu_op     = op;
        o.alu_src    = src;
        o.reg_src    = rs;
        return o;
    endfunction

    task automatic push(input string tag, input logic r, input logic ir, input logic dr,
                        input logic to, input logic ill, input outs_t e);
        step_t s;
        s = {r, ir, dr, to, ill, e};
        step_q.push_back(s);
        tag_q.push_back(tag);
    endtask

    // Apply each queued step for one cycle and compare at the falling edge.
    task automatic drain();
        step_t s;
        string tag;
        while (step_q.size() > 0) begin
            s   = step_q.pop_front();
            tag = tag_q.pop_front();
            rst        = s.rst;
            imem_ready = s.irdy;
            dmem_ready = s.drdy;
            @(negedge clk);
            checks++;
            assert (a_outs === s.exp) else begin
                failures++;
                $error("FAIL %s outs got=%b want=%b", tag, a_outs, s.exp);
            end
            checks++;
            assert (a_retire === exp_retire) else begin
                failures++;
                $error("FAIL %s retire_count got=%0d want=%0d", tag, a_retire, exp_retire);
            end
            checks++;
            assert ({a_illegal, a_bus} === {exp_ill, exp_bus}) else begin
                failures++;
                $error("FAIL %s traps(ill,bus) got=%b%b want=%b%b", tag, a_illegal, a_bus,
                       exp_ill, exp_bus);
            end
            if (b_chk) begin
                b_hold++;
                checks++;
                assert ({b_illegal, b_imem_req, b_mem_read, b_mem_write, b_pc_advance}
                        === 5'b10000) else begin
                    failures++;
                    $error("FAIL %s dut_b trap hold got=%b want=10000", tag,
                           {b_illegal, b_imem_req, b_mem_read, b_mem_write, b_pc_advance});
                end
            end
            @(posedge clk);
            #1;
            if (s.rst) begin
                exp_retire = 4'd0;
                exp_ill    = 1'b0;
                exp_bus    = 1'b0;
            end else begin
                if (s.exp.pc_advance) exp_retire = exp_retire + 4'd1;
                if (s.to)  exp_bus = 1'b1;
                if (s.ill) exp_ill = 1'b1;
            end
        end
    endtask

    task automatic run_alu(input string tag, input logic [6:0] op7, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [3:0] aop, input logic src,
                           input int fwait);
        opcode = op7; funct3 = f3; funct7 = f7;
        for (int i = 0; i < fwait; i++) push({tag, ".Fwait"}, 0, 0, 1, 0, 0, o_fetch(1'b0));
        push({tag, ".F"}, 0, 1, 1, 0, 0, o_fetch(1'b1));
        push({tag, ".D"}, 0, 1, 1, 0, 0, '0);
        push({tag, ".E"}, 0, 1, 1, 0, 0, o_exec(aop, src, 1'b0, 1'b0));
        push({tag, ".W"}, 0, 1, 1, 0, 0, o_wb(aop, src, 1'b0));
        drain();
    endtask

    task automatic run_mem(input string tag, input logic is_ld, input int waits,
                           input logic timeout);
        opcode = is_ld ? 7'b0000011 : 7'b0100011; funct3 = 3'b010; funct7 = 7'b0;
        push({tag, ".F"}, 0, 1, 0, 0, 0, o_fetch(1'b1));
        push({tag, ".D"}, 0, 1, 0, 0, 0, '0);
        push({tag, ".E"}, 0, 1, 0, 0, 0, o_exec(OP_ADD, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < waits; i++)
            push({tag, ".Mwait"}, 0, 1, 0, 0, 0, o_mem(is_ld, !is_ld, 1'b0));
        if (timeout) begin
            push({tag, ".Mtimeout"}, 0, 1, 0, 1, 0, o_mem(1'b0, 1'b0, 1'b0));
        end else begin
            push({tag, ".M"}, 0, 1, 1, 0, 0, o_mem(is_ld, !is_ld, !is_ld));
            if (is_ld) push({tag, ".W"}, 0, 1, 1, 0, 0, o_wb(OP_ADD, 1'b1, 1'b1));
        end
        drain();
    endtask

    task automatic run_branch(input string tag, input logic [2:0] f3, input logic inv);
        opcode = 7'b1100011; funct3 = f3; funct7 = 7'b0;
        push({tag, ".F"}, 0, 1, 1, 0, 0, o_fetch(1'b1));
        push({tag, ".D"}, 0, 1, 1, 0, 0, '0);
        push({tag, ".E"}, 0, 1, 1, 0, 0, o_exec(OP_SUB, 1'b0, 1'b1, inv));
        drain();
    endtask

    task automatic run_idle(input string tag, input int n, input logic r);
        for (int i = 0; i < n; i++) push(tag, r, 1, 1, 0, 0, '0);
        drain();
    endtask

    initial begin
        run_idle("reset", 2, 1'b1);
        run_alu("add", 7'b0110011, 3'b000, 7'b0000000, OP_ADD, 1'b0, 0);
        run_mem("ld_wait3", 1'b1, 3, 1'b0);

        checks++;
        assert (b_illegal === 1'b0) else begin
            failures++;
            $error("FAIL dut_b_pre_bne illegal_instr got=%b want=0", b_illegal);
        end
        run_branch("bne", 3'b001, 1'b1);
        b_chk = 1'b1;
        run_branch("beq", 3'b000, 1'b0);
        run_alu("sub", 7'b0110011, 3'b000, 7'b0100000, OP_SUB, 1'b0, 0);
        run_alu("and", 7'b0110011, 3'b111, 7'b0000000, OP_AND, 1'b0, 0);
        run_alu("or", 7'b0110011, 3'b110, 7'b0000000, OP_OR, 1'b0, 0);
        run_alu("andi", 7'b0010011, 3'b111, 7'b0000000, OP_AND, 1'b1, 0);
        run_alu("ori", 7'b0010011, 3'b110, 7'b0000000, OP_OR, 1'b1, 0);
        for (int i = 0; i < 17; i++)
            run_alu("addi", 7'b0010011, 3'b000, 7'b0000000, OP_ADD, 1'b1, 0);

        run_mem("sd_timeout", 1'b0, 4, 1'b1);
        run_idle("trap_bus", 3, 1'b0);
        b_chk = 1'b0;
        checks++;
        assert (b_hold >= 20) else begin
            failures++;
            $error("FAIL dut_b_trap_cycles got=%0d want>=20", b_hold);
        end
        run_idle("reset2", 1, 1'b1);

        run_mem("sd_ready4", 1'b0, 3, 1'b0);
        run_alu("add_fwait", 7'b0110011, 3'b000, 7'b0000000, OP_ADD, 1'b0, 2);

        // Reset lands in the middle of a load's memory wait.
        opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'b0;
        push("ldrst.F", 0, 1, 0, 0, 0, o_fetch(1'b1));
        push("ldrst.D", 0, 1, 0, 0, 0, '0);
        push("ldrst.E", 0, 1, 0, 0, 0, o_exec(OP_ADD, 1'b1, 1'b0, 1'b0));
        push("ldrst.Mwait", 0, 1, 0, 0, 0, o_mem(1'b1, 1'b0, 1'b0));
        push("ldrst.Mwait", 0, 1, 0, 0, 0, o_mem(1'b1, 1'b0, 1'b0));
        push("ldrst.rst", 1, 1, 1, 0, 0, '0);
        drain();
        run_alu("add_after_rst", 7'b0110011, 3'b000, 7'b0000000, OP_ADD, 1'b0, 0);

        opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000001;
        push("illegal.F", 0, 1, 1, 0, 0, o_fetch(1'b1));
        push("illegal.D", 0, 1, 1, 0, 1, '0);
        drain();
        run_idle("trap_ill", 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
